// File: rtl/read_iq_pkg.sv
// read_iq_pkg: shared quantize width, FSM state type and fixed-point helper for read_iq.
package read_iq_pkg;
  localparam int QUANT_BITS_DEFAULT = 10;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} state_t;
  function automatic logic [31:0] quantize(input logic [15:0] s, input int qb);
    logic signed [31:0] x;
    x = {{16{s[15]}}, s};
    return x <<< qb;
  endfunction
endpackage

// File: rtl/read_iq_if.sv
// read_iq_if: byte-FIFO input and paired I/Q FIFO output signals of read_iq.
interface read_iq_if;
  logic [7:0] in_dout;
  logic in_empty;
  logic in_rd_en;
  logic [31:0] i_out;
  logic [31:0] q_out;
  logic i_wr_en;
  logic q_wr_en;
  logic i_full;
  logic q_full;
  modport slave(input in_dout, in_empty, i_full, q_full, output in_rd_en, i_out, q_out, i_wr_en, q_wr_en);
  modport master(output in_dout, in_empty, i_full, q_full, input in_rd_en, i_out, q_out, i_wr_en, q_wr_en);
endinterface

// File: rtl/read_iq.sv
// read_iq: assembles I_lo,I_hi,Q_lo,Q_hi bytes into quantized 32-bit I/Q samples.
module read_iq
  import read_iq_pkg::*;
#(
  parameter int QUANT_BITS = QUANT_BITS_DEFAULT
) (
  input logic clock,
  input logic reset,
  read_iq_if.slave bus
);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0][7:0] slot_q, slot_d;
  logic [31:0] i_q, i_d, q_q, q_d;
  logic rd, wr;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    slot_d = slot_q;
    i_d = i_q;
    q_d = q_q;
    rd = !reset && state_q == READ && !bus.in_empty;
    wr = !reset && state_q == WRITE && !bus.i_full && !bus.q_full;
    if (rd) begin
      slot_d[cnt_q] = bus.in_dout;
      cnt_d = cnt_q + 2'd1;
      // the last byte is taken straight from the FIFO so the sample is ready on WRITE entry
      if (cnt_q == 2'd3) begin
        state_d = WRITE;
        i_d = quantize({slot_q[1], slot_q[0]}, QUANT_BITS);
        q_d = quantize({bus.in_dout, slot_q[2]}, QUANT_BITS);
      end
    end
    if (wr) state_d = READ;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= READ;
      cnt_q <= '0;
      slot_q <= '0;
      i_q <= '0;
      q_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      slot_q <= slot_d;
      i_q <= i_d;
      q_q <= q_d;
    end
  end
  assign bus.in_rd_en = rd;
  assign bus.i_wr_en = wr;
  assign bus.q_wr_en = wr;
  assign bus.i_out = i_q;
  assign bus.q_out = q_q;
endmodule

// File: tb/tb_read_iq.sv
// tb_read_iq: scoreboard bench for read_iq with behavioural byte/I/Q FIFO models.
module tb_read_iq;
  localparam int QB = 10;
  typedef struct {
    logic [7:0] d;
    int gap;
  } byte_t;
  logic clock = 0;
  logic reset = 1;
  read_iq_if bif();
  read_iq #(.QUANT_BITS(QB)) dut (.clock(clock), .reset(reset), .bus(bif.slave));
  always #5 clock = ~clock;
  byte_t in_q[$];
  logic [63:0] sb[$];
  logic [31:0] i_fifo[$];
  logic [31:0] q_fifo[$];
  int wr_cyc[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic force_i = 0, force_q = 0, rand_bp = 0;
  initial forever @(posedge clock) cyc++;
  function automatic logic [31:0] model(input logic [7:0] lo, input logic [7:0] hi);
    longint v;
    v = longint'($signed({hi, lo}));
    v = v * (longint'(1) << QB);
    return v[31:0];
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push_bytes(input logic [7:0] b0, b1, b2, b3, input int g0, g1, g2, g3);
    in_q.push_back('{b0, g0});
    in_q.push_back('{b1, g1});
    in_q.push_back('{b2, g2});
    in_q.push_back('{b3, g3});
  endtask
  task automatic send(input logic [7:0] b0, b1, b2, b3, input logic [31:0] ei, eq, input int g2);
    sb.push_back({ei, eq});
    push_bytes(b0, b1, b2, b3, 0, 0, g2, 0);
  endtask
  task automatic send_model(input logic [7:0] b0, b1, b2, b3, input int gmax);
    sb.push_back({model(b0, b1), model(b2, b3)});
    push_bytes(b0, b1, b2, b3, $urandom_range(0, gmax), $urandom_range(0, gmax),
               $urandom_range(0, gmax), $urandom_range(0, gmax));
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic wait_idle(input string name);
    int budget;
    budget = 4000;
    while ((in_q.size() != 0 || sb.size() != 0) && budget > 0) begin
      tick(1);
      budget--;
    end
    tests++;
    if (budget == 0) begin
      fails++;
      $display("FAIL %s timeout: in_q=%0d sb=%0d required 0", name, in_q.size(), sb.size());
      in_q.delete();
      sb.delete();
    end
    tick(2);
  endtask
  task automatic wait_drained(input string name);
    int budget;
    budget = 200;
    while (in_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    tests++;
    if (budget == 0) begin
      fails++;
      $display("FAIL %s drain timeout: in_q=%0d required 0", name, in_q.size());
    end
  endtask
  initial begin
    logic pop, wi;
    logic [31:0] oi, oq;
    byte_t h;
    bif.in_empty = 1;
    bif.in_dout = '0;
    bif.i_full = 0;
    bif.q_full = 0;
    forever begin
      @(negedge clock);
      pop = bif.in_rd_en;
      wi = bif.i_wr_en;
      oi = bif.i_out;
      oq = bif.q_out;
      @(posedge clock);
      #1;
      if (pop && in_q.size() > 0) void'(in_q.pop_front());
      if (wi) begin
        i_fifo.push_back(oi);
        q_fifo.push_back(oq);
      end
      if (in_q.size() > 0 && in_q[0].gap > 0) begin
        h = in_q[0];
        h.gap--;
        in_q[0] = h;
        bif.in_empty = 1;
      end else begin
        bif.in_empty = in_q.size() == 0;
        if (in_q.size() > 0) bif.in_dout = in_q[0].d;
      end
      bif.i_full = rand_bp ? $urandom_range(0, 3) == 0 : force_i;
      bif.q_full = rand_bp ? $urandom_range(0, 3) == 0 : force_q;
    end
  end
  initial forever begin
    logic [63:0] e;
    @(negedge clock);
    if (bif.i_wr_en !== bif.q_wr_en) chk("wr_en_pair", {31'd0, bif.q_wr_en}, {31'd0, bif.i_wr_en});
    if (reset && (bif.in_rd_en || bif.i_wr_en)) chk("reset_handshake", {30'd0, bif.in_rd_en, bif.i_wr_en}, 32'd0);
    if (bif.i_wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_write", bif.i_out, 32'hx);
      end else begin
        e = sb.pop_front();
        chk("i_out", bif.i_out, e[63:32]);
        chk("q_out", bif.q_out, e[31:0]);
      end
    end
  end
  initial begin
    logic [63:0] e;
    logic [7:0] b[4];
    tick(3);
    @(negedge clock);
    chk("reset_i_out", bif.i_out, 32'd0);
    chk("reset_q_out", bif.q_out, 32'd0);
    chk("reset_rd_en", {31'd0, bif.in_rd_en}, 32'd0);
    tick(1);
    reset = 0;
    send(8'h01, 8'h00, 8'hFF, 8'hFF, 32'h00000400, 32'hFFFFFC00, 0);
    send(8'hFF, 8'h7F, 8'h00, 8'h80, 32'h01FFFC00, 32'hFE000000, 0);
    wait_idle("directed");
    send(8'h34, 8'h12, 8'hCD, 8'hAB, model(8'h34, 8'h12), model(8'hCD, 8'hAB), 3);
    wait_idle("empty_gap");
    force_q = 1;
    b = '{8'h55, 8'h81, 8'h0F, 8'h3C};
    e = {model(b[0], b[1]), model(b[2], b[3])};
    send(b[0], b[1], b[2], b[3], e[63:32], e[31:0], 0);
    wait_drained("backpressure");
    tick(2);
    send_model(8'h10, 8'h20, 8'h30, 8'h40, 0);
    repeat (10) begin
      @(negedge clock);
      chk("bp_wr_en", {30'd0, bif.i_wr_en, bif.q_wr_en}, 32'd0);
      chk("bp_rd_en", {31'd0, bif.in_rd_en}, 32'd0);
      chk("bp_i_stable", bif.i_out, e[63:32]);
      chk("bp_q_stable", bif.q_out, e[31:0]);
      tick(1);
    end
    force_q = 0;
    wait_idle("bp_release");
    push_bytes(8'h01, 8'h02, 8'h00, 8'h00, 0, 0, 0, 0);
    in_q.pop_back();
    in_q.pop_back();
    wait_drained("mid_reset");
    tick(2);
    reset = 1;
    tick(2);
    reset = 0;
    send(8'h02, 8'h00, 8'h03, 8'h00, 32'h00000800, 32'h00000C00, 0);
    wait_idle("after_mid_reset");
    force_i = 1;
    push_bytes(8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0);
    wait_drained("write_reset");
    tick(3);
    reset = 1;
    tick(2);
    force_i = 0;
    reset = 0;
    tick(3);
    send(8'hFE, 8'hFF, 8'h02, 8'h00, 32'hFFFFF800, 32'h00000800, 0);
    wait_idle("after_write_reset");
    wr_cyc.delete();
    for (int k = 0; k < 100; k++) send_model(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
    wait_idle("stream");
    chk("stream_writes", wr_cyc.size(), 32'd100);
    for (int k = 1; k < wr_cyc.size(); k++) chk("stream_period", wr_cyc[k] - wr_cyc[k-1], 32'd5);
    rand_bp = 1;
    for (int k = 0; k < 60; k++) send_model(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2);
    wait_idle("random");
    rand_bp = 0;
    tick(2);
    chk("fifo_sync", i_fifo.size(), q_fifo.size());
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
